hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 32, meaning the architectural register count; register index width RW = clog2(NREG).
REQ-002 SHALL have parameter FWD_STAGES, default 2, meaning the number of pipeline stages after EX that can forward (stage 1 = MEM, stage FWD_STAGES = WB); legal range 1..6.
REQ-003 SHALL have parameter MDU_MAX, default 1, meaning the maximum number of outstanding multi-cycle (mul/div) operations.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  reset, synchronous and active-low.
REQ-006 id_valid  input  1  ID stage holds a real instruction.
REQ-007 id_rs1, id_rs2  input  RW each  ID source register indices.
REQ-008 id_rs1_used, id_rs2_used  input  1 each  the ID instruction reads that source.
REQ-009 id_rd  input  RW  ID destination index; id_rd_wr  input  1  the ID instruction writes rd.
REQ-010 id_is_load, id_is_mdu  input  1 each  the ID instruction is a load, or a multi-cycle MDU op.
REQ-011 ex_branch_taken  input  1  the EX instruction redirects the PC this cycle.
REQ-012 mdu_done  input  1 / mdu_rd  input  RW  the MDU writes result register mdu_rd this cycle.
REQ-013 stall  output  1  hold PC and IF/ID; flush_if_id  output  1; bubble_id_ex  output  1  load EX with a NOP.
REQ-014 fwd_sel1, fwd_sel2  output  clog2(FWD_STAGES+1) each  EX operand source: 0 = register file, k = stage k.
REQ-015 mdu_busy  output  1  the outstanding MDU count equals MDU_MAX.

Function
REQ-016 SHALL track, for EX and each of the FWD_STAGES later stages, the tuple {valid, rd, rd_wr, is_load}; EX also holds rs1/rs2 and their used flags.
REQ-017 Each cycle, stage k+1 SHALL load stage k, and stage 1 SHALL load EX; stages after EX never stall.
REQ-018 EX SHALL load the ID tuple when stall=0 and ex_branch_taken=0; otherwise EX SHALL load an invalid tuple (bubble).
REQ-019 Load-use: stall SHALL be asserted when EX is valid, is a load, rd_wr=1, rd!=0, and rd equals a used ID source.
REQ-020 Scoreboard: a pending[NREG] bit SHALL be set when an MDU op enters EX with rd!=0, and cleared on mdu_done for mdu_rd.
REQ-021 stall SHALL be asserted when id_valid=1 and any used source register, or id_rd when id_rd_wr=1, has its pending bit set (RAW and WAW).
REQ-022 stall SHALL be asserted when id_is_mdu=1 and mdu_busy=1.
REQ-023 If mdu_done clears a register in the same cycle that ID checks it, the clear SHALL take effect first (no stall for that register).
REQ-024 Register 0 SHALL never be marked pending, never stall, and never forward.
REQ-025 fwd_selN SHALL be the lowest k whose stage is valid, has rd_wr=1, rd!=0, and rd equal to EX rsN with rsN used; otherwise 0; combinational.
REQ-026 ex_branch_taken=1 SHALL assert flush_if_id and bubble_id_ex in the same cycle and overrides stall; an MDU op flushed from ID SHALL NOT set pending.
REQ-027 bubble_id_ex SHALL also equal stall whenever ex_branch_taken=0.
REQ-028 The outstanding MDU counter SHALL increment on MDU entry to EX and decrement on mdu_done; a simultaneous increment and decrement SHALL leave it unchanged; it SHALL never wrap.

Reset
REQ-029 When reset_n=0 at a clock edge, all stage tuples SHALL be set invalid, all pending bits cleared, and the MDU count set to 0; reset SHALL abort any in-flight state.
REQ-030 During and immediately after reset: stall=0, flush_if_id=0, bubble_id_ex=0, fwd_sel1=fwd_sel2=0, mdu_busy=0.

Structure
REQ-031 The stage tuple struct and the fwd_sel encoding constants SHALL live in lib_pkg.
REQ-032 The scoreboard (pending bits plus MDU counter) SHALL be one sub-module, mdu_scoreboard; forwarding and stall logic SHALL stay in the top level.

Verification
REQ-033 Sequence "lw x5" then "add x6,x5,x1" -> exactly one cycle with stall=1 and bubble_id_ex=1; next cycle fwd_sel1=2 (WB) when FWD_STAGES=2.
REQ-034 Sequence "add x3,.." then "sub x4,x3,x3" -> stall=0, fwd_sel1=fwd_sel2=1; an intervening instruction gives 2; both stages writing x3 -> 1 (nearest stage wins).
REQ-035 "mul x7" then "add x8,x7,x0" -> stall holds until mdu_done with mdu_rd=7; the stall drops in the mdu_done cycle.
REQ-036 MDU_MAX=1, two back-to-back mul ops -> second stalls while mdu_busy=1; mdu_done plus a new mul entering EX in the same cycle -> count stays 1.
REQ-037 ex_branch_taken while load-use stall is active -> flush_if_id=1, bubble_id_ex=1, and a flushed mul sets no pending bit.
REQ-038 reset_n=0 with a pending bit set and stages valid -> all outputs 0 next cycle, and a subsequent read of that register does not stall.

Source files
------------

// File: rtl/lib_pkg.sv
// Shared types for the hazard/forwarding slice: per-stage instruction tuple
// and the operand-source encoding used by the forwarding selects.
package lib_pkg;

  localparam int RIDX_W      = 8;
  localparam int FWD_SEL_RF  = 0;
  localparam int FWD_SEL_MEM = 1;

  typedef struct packed {
    logic              valid;
    logic [RIDX_W-1:0] rd;
    logic              rd_wr;
    logic              is_load;
  } stage_t;

  typedef struct packed {
    stage_t            tup;
    logic [RIDX_W-1:0] rs1;
    logic [RIDX_W-1:0] rs2;
    logic              rs1_used;
    logic              rs2_used;
  } ex_stage_t;

  // A stage produces a forwardable result only for a real write to x1..xN.
  function automatic logic writes_reg(stage_t s);
    return s.valid && s.rd_wr && (s.rd != '0);
  endfunction

endpackage

// File: rtl/mdu_scoreboard.sv
// Pending-result bits for multi-cycle MDU destinations plus the outstanding
// MDU operation counter.
module mdu_scoreboard #(
  parameter  int NREG    = 32,
  parameter  int MDU_MAX = 1,
  localparam int RW      = $clog2(NREG),
  localparam int CW      = $clog2(MDU_MAX + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enter,
  input  logic [RW-1:0]   enter_rd,
  input  logic            done,
  input  logic [RW-1:0]   done_rd,
  output logic [NREG-1:0] pend_eff,
  output logic            busy,
  output logic            busy_eff
);

  logic [NREG-1:0] pending;
  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;
  logic [CW-1:0]   count;
  logic            inc;
  logic            dec;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int i = 0; i < NREG; i++) begin
      clr_mask[i] = done && (done_rd == RW'(i));
      set_mask[i] = enter && (enter_rd == RW'(i)) && (i != 0);
    end
  end

  // A completion this cycle already frees its register and its MDU slot for
  // the instruction sitting in ID.
  assign pend_eff = pending & ~clr_mask;
  assign busy     = (count == CW'(MDU_MAX));
  assign busy_eff = busy & ~done;
  assign inc      = enter & ~busy_eff;
  assign dec      = done & (count != '0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending <= '0;
      count   <= '0;
    end else begin
      pending <= pend_eff | set_mask;
      case ({inc, dec})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order pipeline hazard unit: load-use and MDU scoreboard stalls, branch
// flush, and nearest-stage operand forwarding selects for EX.
module hazard_scoreboard
  import lib_pkg::*;
#(
  parameter  int NREG       = 32,
  parameter  int FWD_STAGES = 2,
  parameter  int MDU_MAX    = 1,
  localparam int RW         = $clog2(NREG),
  localparam int SW         = $clog2(FWD_STAGES + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs1,
  input  logic [RW-1:0] id_rs2,
  input  logic          id_rs1_used,
  input  logic          id_rs2_used,
  input  logic [RW-1:0] id_rd,
  input  logic          id_rd_wr,
  input  logic          id_is_load,
  input  logic          id_is_mdu,
  input  logic          ex_branch_taken,
  input  logic          mdu_done,
  input  logic [RW-1:0] mdu_rd,
  output logic          stall,
  output logic          flush_if_id,
  output logic          bubble_id_ex,
  output logic [SW-1:0] fwd_sel1,
  output logic [SW-1:0] fwd_sel2,
  output logic          mdu_busy
);

  ex_stage_t       ex_p0;
  ex_stage_t       ex_nxt;
  stage_t          stage_pn [1:FWD_STAGES];
  logic [NREG-1:0] pend_eff;
  logic            busy_q;
  logic            busy_eff;
  logic            load_use;
  logic            raw_waw;
  logic            mdu_struct;
  logic            hazard;
  logic            ex_load;
  logic            mdu_enter;
  logic            unused_tail_load;

  assign unused_tail_load = stage_pn[FWD_STAGES].is_load;

  assign load_use = ex_p0.tup.is_load && writes_reg(ex_p0.tup) &&
                    ((id_rs1_used && (RIDX_W'(id_rs1) == ex_p0.tup.rd)) ||
                     (id_rs2_used && (RIDX_W'(id_rs2) == ex_p0.tup.rd)));

  assign raw_waw = id_valid &&
                   ((id_rs1_used && (id_rs1 != '0) && pend_eff[id_rs1]) ||
                    (id_rs2_used && (id_rs2 != '0) && pend_eff[id_rs2]) ||
                    (id_rd_wr    && (id_rd  != '0) && pend_eff[id_rd]));

  assign mdu_struct = id_is_mdu && busy_eff;
  assign hazard     = load_use | raw_waw | mdu_struct;
  assign ex_load    = ~hazard & ~ex_branch_taken;
  assign mdu_enter  = ex_load & id_valid & id_is_mdu;

  // A taken branch kills ID regardless of hazards, so it masks the stall.
  assign stall        = reset_n & ~ex_branch_taken & hazard;
  assign flush_if_id  = reset_n & ex_branch_taken;
  assign bubble_id_ex = flush_if_id | stall;
  assign mdu_busy     = reset_n & busy_q;

  always_comb begin
    ex_nxt = '0;
    if (ex_load) begin
      ex_nxt.tup.valid   = id_valid;
      ex_nxt.tup.rd      = RIDX_W'(id_rd);
      ex_nxt.tup.rd_wr   = id_rd_wr;
      ex_nxt.tup.is_load = id_is_load;
      ex_nxt.rs1         = RIDX_W'(id_rs1);
      ex_nxt.rs2         = RIDX_W'(id_rs2);
      ex_nxt.rs1_used    = id_rs1_used;
      ex_nxt.rs2_used    = id_rs2_used;
    end
  end

  // ID -> EX (p0) -> MEM .. WB (stage_pn[1..FWD_STAGES])
  always_ff @(posedge clk) begin
    ex_p0       <= ex_nxt;
    stage_pn[1] <= ex_p0.tup;
    for (int k = 2; k <= FWD_STAGES; k++) begin
      stage_pn[k] <= stage_pn[k-1];
    end
    if (!reset_n) begin
      ex_p0.tup.valid <= 1'b0;
      for (int k = 1; k <= FWD_STAGES; k++) begin
        stage_pn[k].valid <= 1'b0;
      end
    end
  end

  // Walk from the oldest stage down so the nearest producer is written last.
  always_comb begin
    fwd_sel1 = SW'(FWD_SEL_RF);
    fwd_sel2 = SW'(FWD_SEL_RF);
    for (int k = FWD_STAGES; k >= FWD_SEL_MEM; k--) begin
      if (writes_reg(stage_pn[k]) && ex_p0.rs1_used && (stage_pn[k].rd == ex_p0.rs1))
        fwd_sel1 = SW'(k);
      if (writes_reg(stage_pn[k]) && ex_p0.rs2_used && (stage_pn[k].rd == ex_p0.rs2))
        fwd_sel2 = SW'(k);
    end
    if (!reset_n) begin
      fwd_sel1 = SW'(FWD_SEL_RF);
      fwd_sel2 = SW'(FWD_SEL_RF);
    end
  end

  mdu_scoreboard #(
    .NREG    (NREG),
    .MDU_MAX (MDU_MAX)
  ) u_sb (
    .clk      (clk),
    .reset_n  (reset_n),
    .enter    (mdu_enter),
    .enter_rd (id_rd),
    .done     (mdu_done),
    .done_rd  (mdu_rd),
    .pend_eff (pend_eff),
    .busy     (busy_q),
    .busy_eff (busy_eff)
  );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: instruction-level reference model
// checked every cycle, plus hand-computed expectations at key points.
module tb_hazard_scoreboard;

  localparam int N  = 32;
  localparam int F  = 2;
  localparam int MX = 1;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd, mdu_rd;
  logic       id_rs1_used, id_rs2_used, id_rd_wr, id_is_load, id_is_mdu;
  logic       ex_branch_taken, mdu_done;
  logic       stall, flush_if_id, bubble_id_ex, mdu_busy;
  logic [1:0] fwd_sel1, fwd_sel2;

  int n_chk  = 0;
  int n_fail = 0;

  hazard_scoreboard #(.NREG(N), .FWD_STAGES(F), .MDU_MAX(MX)) dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_rd_wr(id_rd_wr), .id_is_load(id_is_load), .id_is_mdu(id_is_mdu),
    .ex_branch_taken(ex_branch_taken), .mdu_done(mdu_done), .mdu_rd(mdu_rd),
    .stall(stall), .flush_if_id(flush_if_id), .bubble_id_ex(bubble_id_ex),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .mdu_busy(mdu_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: what occupies EX and each later stage, which MDU
  // destinations are still outstanding, and how many MDU ops are in flight.
  typedef struct {
    bit v; int rd; bit wr; bit ld; int rs1; int rs2; bit u1; bit u2;
  } rec_t;

  rec_t hist [0:F];
  bit   pend [N];
  int   outst = 0;

  function automatic bit pend_now(int r);
    return (r != 0) && pend[r] && !(mdu_done && (mdu_rd == r));
  endfunction

  initial begin
    for (int k = 0; k <= F; k++) hist[k] = '{default: 0};
    for (int r = 0; r < N; r++) pend[r] = 0;
  end

  always @(negedge clk) begin
    bit   ld, raw, st, e_stall, e_flush, e_busy, enter;
    int   e_f1, e_f2, occ;
    rec_t nw;
    ld = hist[0].v && hist[0].ld && hist[0].wr && (hist[0].rd != 0) &&
         ((id_rs1_used && (id_rs1 == hist[0].rd)) || (id_rs2_used && (id_rs2 == hist[0].rd)));
    raw = id_valid && ((id_rs1_used && pend_now(id_rs1)) ||
                       (id_rs2_used && pend_now(id_rs2)) ||
                       (id_rd_wr    && pend_now(id_rd)));
    occ = outst - ((mdu_done && outst > 0) ? 1 : 0);
    st  = id_is_mdu && (occ >= MX);
    e_stall = reset_n && !ex_branch_taken && (ld || raw || st);
    e_flush = reset_n && ex_branch_taken;
    e_busy  = reset_n && (outst == MX);
    e_f1 = 0;
    e_f2 = 0;
    if (reset_n) begin
      for (int k = 1; k <= F; k++) begin
        if (hist[k].v && hist[k].wr && hist[k].rd != 0) begin
          if (e_f1 == 0 && hist[0].u1 && hist[k].rd == hist[0].rs1) e_f1 = k;
          if (e_f2 == 0 && hist[0].u2 && hist[k].rd == hist[0].rs2) e_f2 = k;
        end
      end
    end
    chk("m_stall",  stall,        e_stall);
    chk("m_flush",  flush_if_id,  e_flush);
    chk("m_bubble", bubble_id_ex, e_flush || e_stall);
    chk("m_fwd1",   fwd_sel1,     e_f1);
    chk("m_fwd2",   fwd_sel2,     e_f2);
    chk("m_busy",   mdu_busy,     e_busy);
    // Inputs are stable until after the next rising edge: advance the model now.
    if (!reset_n) begin
      for (int k = 0; k <= F; k++) hist[k] = '{default: 0};
      for (int r = 0; r < N; r++) pend[r] = 0;
      outst = 0;
    end else begin
      enter = !e_stall && !ex_branch_taken;
      for (int k = F; k >= 1; k--) hist[k] = hist[k-1];
      nw = '{default: 0};
      if (enter) nw = '{id_valid, id_rd, id_rd_wr, id_is_load, id_rs1, id_rs2, id_rs1_used, id_rs2_used};
      hist[0] = nw;
      if (mdu_done) begin
        if (outst > 0) outst--;
        pend[mdu_rd] = 0;
      end
      if (enter && id_valid && id_is_mdu) begin
        outst++;
        if (id_rd != 0) pend[id_rd] = 1;
      end
    end
  end

  task automatic drv(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                     input int rd, input bit wr, input bit ld, input bit mdu);
    id_valid = v; id_rs1 = 5'(rs1); id_rs1_used = u1; id_rs2 = 5'(rs2); id_rs2_used = u2;
    id_rd = 5'(rd); id_rd_wr = wr; id_is_load = ld; id_is_mdu = mdu;
  endtask

  task automatic nop();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset_n = 0; ex_branch_taken = 1; mdu_done = 0; mdu_rd = 0;
    nop();
    neg();
    chk("rst_flush", flush_if_id, 0);
    chk("rst_bubble", bubble_id_ex, 0);
    step(); ex_branch_taken = 0;
    step(); reset_n = 1;
    neg();
    chk("rst_stall", stall, 0);
    chk("rst_busy", mdu_busy, 0);
    chk("rst_fwd1", fwd_sel1, 0);

    // lw x5 ; add x6,x5,x1
    step(); drv(1, 0, 0, 0, 0, 5, 1, 1, 0);
    neg();  chk("lu_pre", stall, 0);
    step(); drv(1, 5, 1, 1, 1, 6, 1, 0, 0);
    neg();  chk("lu_stall", stall, 1); chk("lu_bubble", bubble_id_ex, 1);
    step();
    neg();  chk("lu_release", stall, 0);
    step(); nop();
    neg();  chk("lu_fwd1_wb", fwd_sel1, 2); chk("lu_fwd2_rf", fwd_sel2, 0);
    repeat (3) step();

    // add x3 ; sub x4,x3,x3
    step(); drv(1, 0, 0, 0, 0, 3, 1, 0, 0);
    step(); drv(1, 3, 1, 3, 1, 4, 1, 0, 0);
    neg();  chk("alu_nostall", stall, 0);
    step(); nop();
    neg();  chk("alu_fwd1_mem", fwd_sel1, 1); chk("alu_fwd2_mem", fwd_sel2, 1);
    // add x3 ; nop ; sub x4,x3,x3
    step(); drv(1, 0, 0, 0, 0, 3, 1, 0, 0);
    step(); drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); drv(1, 3, 1, 3, 1, 4, 1, 0, 0);
    step(); nop();
    neg();  chk("gap_fwd1_wb", fwd_sel1, 2); chk("gap_fwd2_wb", fwd_sel2, 2);
    // add x3 ; add x3 ; sub x4,x3,x3
    step(); drv(1, 0, 0, 0, 0, 3, 1, 0, 0);
    step(); drv(1, 0, 0, 0, 0, 3, 1, 0, 0);
    step(); drv(1, 3, 1, 3, 1, 4, 1, 0, 0);
    step(); nop();
    neg();  chk("near_fwd1", fwd_sel1, 1); chk("near_fwd2", fwd_sel2, 1);
    // x0 never forwards and never causes a load-use stall
    step(); drv(1, 0, 0, 0, 0, 0, 1, 0, 0);
    step(); drv(1, 0, 1, 0, 1, 4, 1, 0, 0);
    step(); nop();
    neg();  chk("x0_fwd1", fwd_sel1, 0);
    step(); drv(1, 0, 0, 0, 0, 0, 1, 1, 0);
    step(); drv(1, 0, 1, 0, 1, 6, 1, 0, 0);
    neg();  chk("x0_lu", stall, 0);
    step(); nop();
    repeat (3) step();

    // mul x7 ; add x8,x7,x0
    step(); drv(1, 1, 1, 2, 1, 7, 1, 0, 1);
    step(); drv(1, 7, 1, 0, 1, 8, 1, 0, 0);
    neg();  chk("raw_stall", stall, 1); chk("raw_busy", mdu_busy, 1);
    step(); step();
    neg();  chk("raw_hold", stall, 1);
    step(); mdu_done = 1; mdu_rd = 7;
    neg();  chk("raw_done_release", stall, 0); chk("raw_done_busy", mdu_busy, 1);
    step(); mdu_done = 0; nop();
    neg();  chk("raw_after_busy", mdu_busy, 0);

    // mul x9 ; mul x10 with one MDU slot
    step(); drv(1, 1, 1, 2, 1, 9, 1, 0, 1);
    step(); drv(1, 1, 1, 2, 1, 10, 1, 0, 1);
    neg();  chk("mdu2_stall", stall, 1); chk("mdu2_busy", mdu_busy, 1);
    step();
    neg();  chk("mdu2_hold", stall, 1);
    step(); mdu_done = 1; mdu_rd = 9;
    neg();  chk("mdu2_swap", stall, 0);
    step(); mdu_done = 0; nop();
    neg();  chk("mdu2_count_kept", mdu_busy, 1);
    step(); mdu_done = 1; mdu_rd = 10;
    step(); mdu_done = 0;
    neg();  chk("mdu2_drained", mdu_busy, 0);

    // lw x5 ; mul x11,x5,x1 flushed by a taken branch during the load-use stall
    step(); drv(1, 0, 0, 0, 0, 5, 1, 1, 0);
    step(); drv(1, 5, 1, 1, 1, 11, 1, 0, 1); ex_branch_taken = 1;
    neg();  chk("br_flush", flush_if_id, 1); chk("br_bubble", bubble_id_ex, 1);
    step(); ex_branch_taken = 0; nop();
    neg();  chk("br_no_mdu", mdu_busy, 0);
    step(); drv(1, 11, 1, 11, 1, 12, 1, 0, 0);
    neg();  chk("br_no_pending", stall, 0);

    // spurious completion with nothing outstanding must not wrap the counter
    step(); nop(); mdu_done = 1; mdu_rd = 3;
    step(); mdu_done = 0;
    neg();  chk("no_wrap", mdu_busy, 0);

    // reset with x13 pending and valid stages in flight
    step(); drv(1, 1, 1, 2, 1, 13, 1, 0, 1);
    step(); drv(1, 0, 0, 0, 0, 3, 1, 0, 0);
    step(); drv(1, 3, 1, 0, 0, 4, 1, 0, 0);
    neg();  chk("pre_rst_busy", mdu_busy, 1);
    step(); reset_n = 0; drv(1, 13, 1, 0, 1, 14, 1, 0, 0);
    neg();  chk("in_rst_stall", stall, 0); chk("in_rst_busy", mdu_busy, 0);
    step(); reset_n = 1;
    neg();  chk("post_rst_stall", stall, 0); chk("post_rst_busy", mdu_busy, 0);
    chk("post_rst_fwd1", fwd_sel1, 0);
    step(); nop();
    neg();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
